// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, queue entry layout and the default boot PC.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO with synchronous flush; head visible combinationally, zero when empty.
// Latency: push visible at head the next cycle; push to a full queue is dropped unless a pop coincides.
module fetch_queue #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: one outstanding imem request, {pc,instr} queue to decode; redirects squash in-flight data.
// Optional FETCH_PERF_EN adds stall/discard counters; requests stop while the queue is full.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  req_pc_q;
    logic [CNT_W-1:0] occupancy;
    logic         q_empty;
    logic         granted;
    logic         push;
    logic         pop;
    logic         drop;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic         unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_addr = {fetch_pc_q[31:2], 2'b00};
    assign imem_req  = !reset && (state_q == ISSUE) && (occupancy < CNT_W'(BUF_DEPTH)) && !redirect_valid;
    assign granted   = imem_req && imem_gnt;

    // A redirect squashes the response arriving in the same cycle as well as any still in flight.
    assign push = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    assign drop = imem_rvalid && ((state_q == DISCARD) || ((state_q == WAIT) && redirect_valid));
    assign pop  = out_valid && out_ready && !redirect_valid;

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};
    assign out_valid  = !q_empty;
    assign out_pc     = head_entry.pc;
    assign out_instr  = head_entry.instr;

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .empty     (q_empty),
        .count     (occupancy)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE:   if (granted) state_d = WAIT;
            WAIT:    if (imem_rvalid) state_d = ISSUE;
                     else if (redirect_valid) state_d = DISCARD;
            DISCARD: if (imem_rvalid) state_d = ISSUE;
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ISSUE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (granted) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
                req_pc_q   <= imem_addr;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt   <= '0;
            perf_discard_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (drop) perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    // With no request outstanding, a response can only be a memory-side protocol error.
    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (state_q == ISSUE)));

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-stage controller that sequences instruction fetch over a split-transaction instruction-memory port.
- Owns the fetch PC and issues one request at a time: request/grant, then data returned later on rvalid.
- Buffers returned {pc, instr} pairs in a small flushable queue and presents them to decode with valid/ready.
- Handles branch/jump redirects, including dropping a response that is already in flight.

Parameters:
- RESET_PC, 32'h0000_3000: fetch PC loaded on reset.
- BUF_DEPTH, 2: instruction-queue entries; legal values 1..4.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- redirect_valid, input, 1: redirect the fetch stream this cycle.
- redirect_pc, input, 32: redirect target; bits [1:0] ignored.
- imem_req, output, 1: request valid.
- imem_addr, output, 32: word-aligned request address.
- imem_gnt, input, 1: request accepted this cycle (handshake when imem_req && imem_gnt).
- imem_rvalid, input, 1: response data valid; arrives at least 1 cycle after its grant.
- imem_rdata, input, 32: response instruction.
- out_valid, output, 1: queue head valid.
- out_pc, output, 32: PC of head entry.
- out_instr, output, 32: instruction of head entry.
- out_ready, input, 1: decode accepts head; low means stall.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC; state = ISSUE; queue empty.
  - out_valid = 0; out_pc / out_instr = 0; imem_req = 0 (combinational, forced low while reset is high).
- States:
  - ISSUE: no request outstanding.
    - imem_req = (occupancy < BUF_DEPTH) && !redirect_valid; imem_addr = {fetch_pc[31:2], 2'b00}.
    - On grant: fetch_pc += 4 (modulo 2^32, wraps silently); go to WAIT.
  - WAIT: one request outstanding; imem_req = 0.
    - On imem_rvalid: push {pc_of_request, imem_rdata}; go to ISSUE.
  - DISCARD: outstanding response belongs to a squashed path; imem_req = 0.
    - On imem_rvalid: drop the data, no push; go to ISSUE.
- Redirect (any state, highest priority):
  - Queue flushed; fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Any pop that cycle is ignored.
  - No request is issued in the redirect cycle.
  - Next state:
    - ISSUE -> ISSUE.
    - WAIT without rvalid that cycle -> DISCARD.
    - WAIT with rvalid that cycle -> data dropped, ISSUE.
    - DISCARD with rvalid -> ISSUE; DISCARD without rvalid -> stays DISCARD.
- Queue:
  - out_valid = !empty; head drives out_pc / out_instr.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - The issue gate guarantees push never overflows.
  - imem_rvalid in ISSUE is a protocol error: ignored, flagged by simulation assertion.
- Latency (gnt with request, rvalid 1 cycle later):
  - First out_valid 2 cycles after the first post-reset request cycle.
  - Sustained throughput is 1 instruction per 2 cycles.
- Reset mid-transaction: in-flight response is not tracked. The memory model must be reset concurrently.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_discard_cnt[31:0].
  - perf_stall_cnt increments each cycle with out_valid && !out_ready.
  - perf_discard_cnt increments for each response dropped (DISCARD, or redirect coinciding with rvalid).
  - Both are cleared by reset and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - state enum {ISSUE, WAIT, DISCARD}.
  - RESET_PC_DEFAULT constant.
  - fetch_entry_t struct {pc[31:0], instr[31:0]}.
- One sub-module: fetch_queue, a parameterised circular FIFO with synchronous flush, push/pop and occupancy output.

Test Plan:
- Reset, then gnt held high, rvalid 1 cycle after each grant, out_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; out_pc matches, out_instr equals the memory contents.
- out_ready=0 with BUF_DEPTH=2 -> after 2 pushes imem_req stays 0, out_pc holds 0x3000; release ready -> fetching resumes at 0x3008.
- redirect_valid with redirect_pc=0x3403 while in WAIT, rvalid 3 cycles later -> response dropped, queue empty, next request address 0x3400, first out_pc 0x3400.
- Redirect in the same cycle as rvalid and out_ready=1 -> nothing pushed or popped, out_valid=0 next cycle.
- gnt withheld for 5 cycles -> imem_req and imem_addr=0x3000 stable throughout; fetch_pc unchanged.
- With FETCH_PERF_EN: 4 stalled cycles plus one discard -> perf_stall_cnt=4, perf_discard_cnt=1; both read 0 after reset.
